// File: rtl/mc_control.sv
// mc_control: multi-cycle instruction sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and traps on
// illegal encodings. Only the opcode and funct fields of the fetched word are
// kept, because decode never looks at the other bits.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   instr[31:0]          instruction word, captured in FETCH on mem_ready
//   mem_ready            memory access completes this cycle
//   stall                freeze request
//   pc_we, ir_we, reg_we write enables
//   mem_rd, mem_wr       memory strobes
//   alu_op               0=ADD 1=SUB 2=AND 3=OR 4=MUL 5=LUI
//   alu_src_imm          ALU B operand is the immediate
//   wb_sel               write-back source: 0=ALU, 1=memory
//   state[2:0]           current FSM state
//   retire               one-cycle pulse when an instruction completes
//   illegal              sticky illegal-instruction flag
//
// state  | meaning
// FETCH  | read instruction, capture IR on mem_ready
// DECODE | classify IR; NOP retires here, illegal goes to TRAP
// EXEC   | drive ALU controls; MUL stays MUL_CYCLES cycles
// MEM    | LW reads / SW writes until mem_ready
// WB     | register write and retire
// TRAP   | dead until reset
module mc_control #(
  parameter int MUL_CYCLES = 4,
  parameter int ALU_OP_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  input  logic                stall,
  output logic                pc_we,
  output logic                ir_we,
  output logic                reg_we,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic                wb_sel,
  output logic [2:0]          state,
  output logic                retire,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RALU = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_NOP  = 6'b000000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b110010;

  state_t     st;
  logic [5:0] ir_op;
  logic [5:0] ir_fn;
  logic [3:0] mul_cnt;
  logic       illegal_q;

  // Middle instruction bits carry register/immediate fields this block never uses.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  logic is_ralu, is_ori, is_lui, is_lw, is_sw, is_nop, is_mul, fn_ok, dec_illegal;
  logic [ALU_OP_W-1:0] dec_op;

  always_comb begin
    is_ralu = (ir_op == OP_RALU);
    is_ori  = (ir_op == OP_ORI);
    is_lui  = (ir_op == OP_LUI);
    is_lw   = (ir_op == OP_LW);
    is_sw   = (ir_op == OP_SW);
    is_nop  = (ir_op == OP_NOP);
    is_mul  = is_ralu && (ir_fn == FN_MUL);
    fn_ok   = (ir_fn == FN_ADD) || (ir_fn == FN_SUB) || (ir_fn == FN_AND) ||
              (ir_fn == FN_OR)  || (ir_fn == FN_MUL);
    dec_illegal = !((is_ralu && fn_ok) || is_ori || is_lui || is_lw || is_sw || is_nop);

    // Loads/stores use ADD for address generation.
    dec_op = ALU_OP_W'(0);
    if (is_ori) dec_op = ALU_OP_W'(3);
    if (is_lui) dec_op = ALU_OP_W'(5);
    if (is_ralu) begin
      case (ir_fn)
        FN_SUB:  dec_op = ALU_OP_W'(1);
        FN_AND:  dec_op = ALU_OP_W'(2);
        FN_OR:   dec_op = ALU_OP_W'(3);
        FN_MUL:  dec_op = ALU_OP_W'(4);
        default: dec_op = ALU_OP_W'(0);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_FETCH;
      ir_op     <= '0;
      ir_fn     <= '0;
      mul_cnt   <= '0;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      case (st)
        S_FETCH: begin
          if (mem_ready) begin
            ir_op <= instr[31:26];
            ir_fn <= instr[5:0];
            st    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_illegal) begin
            st        <= S_TRAP;
            illegal_q <= 1'b1;
          end else if (is_nop) begin
            st <= S_FETCH;
          end else begin
            st      <= S_EXEC;
            mul_cnt <= 4'(MUL_CYCLES - 1);
          end
        end
        S_EXEC: begin
          // Counter reaches zero on the last MUL cycle; other ops exit at once.
          if (is_mul && (mul_cnt != 4'd0)) mul_cnt <= mul_cnt - 4'd1;
          else if (is_lw || is_sw)         st <= S_MEM;
          else                             st <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) st <= is_lw ? S_WB : S_FETCH;
        end
        S_WB:    st <= S_FETCH;
        S_TRAP:  st <= S_TRAP;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Strobes follow state; enables and retire are suppressed while stalled.
  always_comb begin
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    retire      = 1'b0;
    case (st)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = mem_ready && !stall;
        pc_we  = mem_ready && !stall;
      end
      S_DECODE: retire = is_nop && !dec_illegal && !stall;
      S_EXEC: begin
        alu_op      = dec_op;
        alu_src_imm = is_ori || is_lui || is_lw || is_sw;
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = is_sw;
        retire = is_sw && mem_ready && !stall;
      end
      S_WB: begin
        reg_we = !stall;
        wb_sel = is_lw;
        retire = !stall;
      end
      default: ;
    endcase
  end

  assign state   = st;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        pc_we, ir_we, reg_we, mem_rd, mem_wr, alu_src_imm, wb_sel, retire, illegal;
  logic [3:0]  alu_op;
  logic [2:0]  state;

  mc_control #(.MUL_CYCLES(4), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .stall(stall),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel), .state(state),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = 32'h3001_5020;
  localparam logic [31:0] I_MUL  = 32'h3000_0032;
  localparam logic [31:0] I_ORI  = 32'h3400_0000;
  localparam logic [31:0] I_LUI  = 32'h3800_0000;
  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_BADO = 32'hFC00_0000;
  localparam logic [31:0] I_BADF = 32'h3000_0001;

  typedef struct {
    string       name;
    logic [15:0] e;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] act;
  assign act = {state, pc_we, ir_we, reg_we, mem_rd, mem_wr, alu_op, alu_src_imm, wb_sel, retire, illegal};

  // {state, pc_we, ir_we, reg_we, mem_rd, mem_wr, alu_op, imm, wb_sel, retire, illegal}
  function automatic logic [15:0] ev(input logic [2:0] s, input logic pcw, input logic irw,
                                     input logic rw, input logic mrd, input logic mwr,
                                     input logic [3:0] op, input logic imm, input logic wbs,
                                     input logic ret, input logic ill);
    return {s, pcw, irw, rw, mrd, mwr, op, imm, wbs, ret, ill};
  endfunction

  function automatic logic [15:0] e_fetch(input logic we);
    return ev(3'd0, we, we, 0, 1, 0, 4'd0, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_dec(input logic ret);
    return ev(3'd1, 0, 0, 0, 0, 0, 4'd0, 0, 0, ret, 0);
  endfunction
  function automatic logic [15:0] e_exec(input logic [3:0] op, input logic imm);
    return ev(3'd2, 0, 0, 0, 0, 0, op, imm, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_wb(input logic wbs);
    return ev(3'd4, 0, 0, 1, 0, 0, 4'd0, 0, wbs, 1, 0);
  endfunction
  localparam logic [15:0] E_TRAP = 16'b101_00000_0000_0001;

  // One clock of stimulus plus the response expected in that same cycle.
  task automatic cyc(input string nm, input logic r, input logic [31:0] i,
                     input logic mr, input logic st, input logic [15:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n     = r;
    instr     = i;
    mem_ready = mr;
    stall     = st;
    x.name    = nm;
    x.e       = e;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_tests++;
      if (act !== x.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b (state pcw irw rw mrd mwr op imm wbs ret ill)",
                 x.name, act, x.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc("reset", 0, I_NOP, 0, 0, e_fetch(0));

    cyc("add_fetch", 1, I_ADD, 1, 0, e_fetch(1));
    cyc("add_dec",   1, 0, 1, 0, e_dec(0));
    cyc("add_exec",  1, 0, 1, 0, e_exec(4'd0, 0));
    cyc("add_wb",    1, 0, 1, 0, e_wb(0));

    cyc("mul_fetch", 1, I_MUL, 1, 0, e_fetch(1));
    cyc("mul_dec",   1, 0, 1, 0, e_dec(0));
    for (int k = 0; k < 4; k++) cyc("mul_exec", 1, 0, 1, 0, e_exec(4'd4, 0));
    cyc("mul_wb",    1, 0, 1, 0, e_wb(0));

    cyc("ori_fetch", 1, I_ORI, 1, 0, e_fetch(1));
    cyc("ori_dec",   1, 0, 1, 0, e_dec(0));
    cyc("ori_exec",  1, 0, 1, 0, e_exec(4'd3, 1));
    cyc("ori_wb_stall", 1, 0, 1, 1, ev(3'd4, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0));
    cyc("ori_wb",    1, 0, 1, 0, e_wb(0));

    cyc("lui_fetch", 1, I_LUI, 1, 0, e_fetch(1));
    cyc("lui_dec",   1, 0, 1, 0, e_dec(0));
    cyc("lui_exec",  1, 0, 1, 0, e_exec(4'd5, 1));
    cyc("lui_wb",    1, 0, 1, 0, e_wb(0));

    cyc("lw_fetch", 1, I_LW, 1, 0, e_fetch(1));
    cyc("lw_dec",   1, 0, 1, 0, e_dec(0));
    cyc("lw_exec",  1, 0, 1, 0, e_exec(4'd0, 1));
    for (int k = 0; k < 3; k++)
      cyc("lw_mem_wait", 1, 0, 0, 0, ev(3'd3, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0));
    cyc("lw_mem_stall", 1, 0, 1, 1, ev(3'd3, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0));
    cyc("lw_mem_done",  1, 0, 1, 0, ev(3'd3, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0));
    cyc("lw_wb",    1, 0, 1, 0, e_wb(1));

    cyc("sw_fetch", 1, I_SW, 1, 0, e_fetch(1));
    cyc("sw_dec",   1, 0, 1, 0, e_dec(0));
    cyc("sw_exec",  1, 0, 1, 0, e_exec(4'd0, 1));
    cyc("sw_mem_wait", 1, 0, 0, 0, ev(3'd3, 0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0));
    cyc("sw_mem_done", 1, 0, 1, 0, ev(3'd3, 0, 0, 0, 0, 1, 4'd0, 0, 0, 1, 0));

    cyc("nop_fetch", 1, I_NOP, 1, 0, e_fetch(1));
    cyc("nop_dec",   1, 0, 1, 0, e_dec(1));

    cyc("stall_fetch0", 1, I_ADD, 1, 1, e_fetch(0));
    cyc("stall_fetch1", 1, I_ADD, 1, 1, e_fetch(0));
    cyc("stall_release", 1, I_ADD, 1, 0, e_fetch(1));
    cyc("stall_dec",  1, 0, 1, 0, e_dec(0));
    cyc("stall_exec", 1, 0, 1, 0, e_exec(4'd0, 0));
    cyc("stall_wb",   1, 0, 1, 0, e_wb(0));

    // A stall inside EXEC must stretch MUL by exactly one cycle.
    cyc("muls_fetch", 1, I_MUL, 1, 0, e_fetch(1));
    cyc("muls_dec",   1, 0, 1, 0, e_dec(0));
    cyc("muls_exec",  1, 0, 1, 0, e_exec(4'd4, 0));
    cyc("muls_stall", 1, 0, 1, 1, e_exec(4'd4, 0));
    for (int k = 0; k < 3; k++) cyc("muls_exec", 1, 0, 1, 0, e_exec(4'd4, 0));
    cyc("muls_wb",    1, 0, 1, 0, e_wb(0));

    // Reset dropped between edges in the middle of MUL.
    cyc("mulr_fetch", 1, I_MUL, 1, 0, e_fetch(1));
    cyc("mulr_dec",   1, 0, 1, 0, e_dec(0));
    cyc("mulr_exec",  1, 0, 1, 0, e_exec(4'd4, 0));
    cyc("mulr_exec",  1, 0, 1, 0, e_exec(4'd4, 0));
    cyc("mulr_async_rst", 0, 0, 0, 0, e_fetch(0));
    cyc("post_rst_fetch", 1, I_ADD, 1, 0, e_fetch(1));
    cyc("post_rst_dec",   1, 0, 1, 0, e_dec(0));
    cyc("post_rst_exec",  1, 0, 1, 0, e_exec(4'd0, 0));
    cyc("post_rst_wb",    1, 0, 1, 0, e_wb(0));

    cyc("bad_op_fetch", 1, I_BADO, 1, 0, e_fetch(1));
    cyc("bad_op_dec",   1, 0, 1, 0, e_dec(0));
    for (int k = 0; k < 3; k++) cyc("bad_op_trap", 1, I_ADD, 1, 0, E_TRAP);
    cyc("bad_op_rst",   0, 0, 0, 0, e_fetch(0));

    cyc("bad_fn_fetch", 1, I_BADF, 1, 0, e_fetch(1));
    cyc("bad_fn_dec",   1, 0, 1, 0, e_dec(0));
    for (int k = 0; k < 2; k++) cyc("bad_fn_trap", 1, I_ADD, 1, 0, E_TRAP);
    cyc("bad_fn_rst",   0, 0, 0, 0, e_fetch(0));

    cyc("end_fetch", 1, I_NOP, 1, 0, e_fetch(1));
    cyc("end_dec",   1, 0, 1, 0, e_dec(1));

    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, EXEC-state cycles spent on MUL (legal range 1..15).
REQ-002 SHALL have parameter ALU_OP_W, default 4, width of alu_op.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port instr  in  32  instruction from memory, sampled in FETCH when mem_ready=1.
REQ-006 SHALL have port mem_ready  in  1  memory access complete this cycle.
REQ-007 SHALL have port stall  in  1  freeze request.
REQ-008 SHALL have port pc_we, ir_we, reg_we  out  1 each  write enables.
REQ-009 SHALL have port mem_rd, mem_wr  out  1 each  memory strobes.
REQ-010 SHALL have port alu_op  out  ALU_OP_W  0=ADD 1=SUB 2=AND 3=OR 4=MUL 5=LUI.
REQ-011 SHALL have port alu_src_imm  out  1  ALU B operand is immediate.
REQ-012 SHALL have port wb_sel  out  1  0=ALU result, 1=memory data.
REQ-013 SHALL have port state  out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5.
REQ-014 SHALL have port retire  out  1  one-cycle pulse when an instruction completes.
REQ-015 SHALL have port illegal  out  1  sticky illegal-instruction flag.

Function
REQ-016 SHALL decode opcode instr[31:26]: 001100 R-ALU, 001101 ORI, 001110 LUI, 100011 LW, 101011 SW, 000000 NOP; all others illegal.
REQ-017 SHALL decode R-ALU funct instr[5:0]: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 110010 MUL; other funct illegal.
REQ-018 SHALL latch instr into internal IR when state=FETCH, mem_ready=1, stall=0; decode uses IR only.
REQ-019 FETCH: mem_rd=1; ir_we=pc_we=mem_ready (combinational); on mem_ready -> DECODE, else stay.
REQ-020 DECODE: illegal -> TRAP; NOP -> FETCH with retire=1; otherwise -> EXEC, MUL counter loaded with MUL_CYCLES-1.
REQ-021 EXEC: alu_op/alu_src_imm per IR (ORI: OR,imm; LUI: LUI,imm; LW/SW: ADD,imm); non-MUL leaves after 1 cycle; MUL leaves after exactly MUL_CYCLES cycles.
REQ-022 EXEC exit: R-ALU/ORI/LUI -> WB; LW/SW -> MEM.
REQ-023 MEM: LW asserts mem_rd, SW asserts mem_wr, held until mem_ready; then LW -> WB, SW -> FETCH with retire=1.
REQ-024 WB: reg_we=1 for exactly one cycle, wb_sel=1 for LW else 0, retire=1, -> FETCH.
REQ-025 TRAP: all enables and strobes 0, illegal=1, state held until reset.
REQ-026 stall=1: state, IR, MUL counter hold; pc_we, ir_we, reg_we, retire forced 0; mem_rd/mem_wr keep their state-derived value; mem_ready ignored.
REQ-027 Outputs not named active in a state SHALL be 0 in that state.
REQ-028 Latency with mem_ready=1, stall=0: ADD/ORI/LUI 4 cycles, MUL 3+MUL_CYCLES, LW 5, SW 4, NOP 2 (FETCH entry to retire inclusive).

Reset
REQ-029 rst_n=0 SHALL immediately force state=FETCH, IR=0, MUL counter=0, illegal=0, retire=0.
REQ-030 Reset mid-operation (any state incl. MUL in progress, MEM waiting, TRAP) SHALL abort it without retire; first post-reset cycle is FETCH with mem_rd=1.

Verification
REQ-031 ADD 0x3001_5020 (funct 100000), mem_ready=1 -> states 0,1,2,4; alu_op=0 in EXEC; reg_we=1 and retire=1 in WB only.
REQ-032 MUL funct 110010, MUL_CYCLES=4 -> EXEC held 4 cycles, alu_op=4, then WB; retire 7 cycles after FETCH entry.
REQ-033 LW opcode 100011, mem_ready low 3 cycles in MEM -> mem_rd held 4 cycles, wb_sel=1 in WB, single reg_we pulse.
REQ-034 Opcode 111111 or R-ALU funct 110010 replaced by 000001 -> DECODE then TRAP, illegal=1, no reg_we/retire thereafter; rst_n low clears illegal.
REQ-035 stall=1 for 2 cycles during FETCH with mem_ready=1 -> no ir_we/pc_we pulse while stalled; exactly one ir_we after release.
REQ-036 rst_n asserted asynchronously mid-MUL -> state=0 before next clk edge, no retire, next instruction executes normally.
